// File: rtl/mem_addr_sched_if.sv
// Bundle of requester, dual-rail bus and status signals around mem_addr_sched.
// The slave view belongs to the scheduler and the master view to whatever drives it.
interface mem_addr_sched_if #(
  parameter int AW = 4
) ();
  logic          pc_req;
  logic [AW-1:0] pc_addr;
  logic          pc_gnt;
  logic          ins_req;
  logic [AW-1:0] ins_addr;
  logic          ins_gnt;
  logic [1:0]    ph0;
  logic [2*AW-1:0] addr_dr;
  logic          mem_ack;
  logic          busy;
  logic          err;
  logic          err_clr;

  modport slave (
    input  pc_req, pc_addr, ins_req, ins_addr, mem_ack, err_clr,
    output pc_gnt, ins_gnt, ph0, addr_dr, busy, err
  );

  modport master (
    output pc_req, pc_addr, ins_req, ins_addr, mem_ack, err_clr,
    input  pc_gnt, ins_gnt, ph0, addr_dr, busy, err
  );
endinterface

// File: rtl/mem_addr_sched.sv
// Arbitrates PC fetch and operand requests onto a dual-rail address bus and
// runs the four-phase DATA/NULL handshake against a synchronized completion ack.
module mem_addr_sched #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  mem_addr_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    NULLW = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ack_m, ack_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            src_q, src_d;
  logic            last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            sel_ins;
  logic            err_d, pc_gnt_d, ins_gnt_d, busy_d;
  logic [1:0]      ph0_d;
  logic [2*AW-1:0] addr_dr_d;

  function automatic logic [2*AW-1:0] dual_rail(input logic [AW-1:0] a);
    logic [2*AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) begin
      r[2*i +: 2] = a[i] ? 2'b10 : 2'b01;
    end
    return r;
  endfunction

  // mem_ack is asynchronous to clk; only ack_s feeds the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= bus.mem_ack;
      ack_s <= ack_m;
    end
  end

  // src/last encoding: 1 = instruction requester, 0 = PC requester
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    last_d    = last_q;
    addr_d    = addr_q;
    sel_ins   = 1'b0;
    pc_gnt_d  = 1'b0;
    ins_gnt_d = 1'b0;
    err_d     = bus.err & ~bus.err_clr;
    unique case (state_q)
      IDLE: begin
        if ((bus.pc_req || bus.ins_req) && !ack_s) begin
          sel_ins = bus.ins_req && (!bus.pc_req || !last_q);
          src_d   = sel_ins;
          addr_d  = sel_ins ? bus.ins_addr : bus.pc_addr;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ack_s) begin
          cnt_d   = '0;
          state_d = NULLW;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      NULLW: begin
        if (!ack_s) begin
          pc_gnt_d  = ~src_q;
          ins_gnt_d = src_q;
          last_d    = src_q;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus word derives from the next state so ph0 and addr_dr switch on one edge
  always_comb begin
    ph0_d     = 2'b00;
    addr_dr_d = '0;
    busy_d    = (state_d != IDLE);
    if (state_d == DATA) begin
      ph0_d     = src_d ? 2'b10 : 2'b01;
      addr_dr_d = dual_rail(addr_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      bus.ph0     <= 2'b00;
      bus.addr_dr <= '0;
      bus.pc_gnt  <= 1'b0;
      bus.ins_gnt <= 1'b0;
      bus.busy    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      bus.ph0     <= ph0_d;
      bus.addr_dr <= addr_dr_d;
      bus.pc_gnt  <= pc_gnt_d;
      bus.ins_gnt <= ins_gnt_d;
      bus.busy    <= busy_d;
      bus.err     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    src_q  <= src_d;
    addr_q <= addr_d;
  end
endmodule

// File: tb/tb_mem_addr_sched.sv
// Directed bench for mem_addr_sched: stimulus queues expected bus events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_addr_sched;
  localparam int AW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_addr_sched_if #(.AW(AW)) bus ();

  mem_addr_sched #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef enum int {EV_DATA, EV_NULL, EV_PCG, EV_INSG, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [1:0]  ph0;
    logic [7:0]  addr;
    int          at;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [1:0] p, input logic [7:0] a, input int at);
    ev_t e;
    e.kind = k;
    e.ph0  = p;
    e.addr = a;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event at cycle %0d: got kind %0d, expected no event", cyc, k);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_cycle", cyc, e.at);
      if (k == EV_DATA) begin
        chk("ph0", {30'd0, bus.ph0}, {30'd0, e.ph0});
        chk("addr_dr", {24'd0, bus.addr_dr}, {24'd0, e.addr});
      end
    end
  endtask

  initial begin : monitor
    logic [1:0] prev_ph0;
    logic       prev_err;
    prev_ph0 = 2'b00;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_ph0 == 2'b00 && bus.ph0 != 2'b00) observe(EV_DATA);
      if (prev_ph0 != 2'b00 && bus.ph0 == 2'b00) observe(EV_NULL);
      if (bus.pc_gnt === 1'b1) observe(EV_PCG);
      if (bus.ins_gnt === 1'b1) observe(EV_INSG);
      if (bus.pc_gnt === 1'b1 || bus.ins_gnt === 1'b1)
        chk("gnt_exclusive", {31'd0, bus.pc_gnt & bus.ins_gnt}, 32'd0);
      if (bus.ph0 != 2'b00) chk("busy_with_data", {31'd0, bus.busy}, 32'd1);
      if (prev_err == 1'b0 && bus.err === 1'b1) observe(EV_ERR);
      prev_ph0 = bus.ph0;
      prev_err = bus.err;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic rand_inputs();
    bus.pc_req   = 1'($urandom);
    bus.pc_addr  = 4'($urandom);
    bus.ins_req  = 1'($urandom);
    bus.ins_addr = 4'($urandom);
    bus.mem_ack  = 1'($urandom);
    bus.err_clr  = 1'($urandom);
  endtask

  initial begin : stimulus
    int c0;
    int d;
    rst = 1'b1;
    rand_inputs();
    repeat (3) begin
      @(negedge clk);
      chk("rst_ph0", {30'd0, bus.ph0}, 32'd0);
      chk("rst_addr_dr", {24'd0, bus.addr_dr}, 32'd0);
      chk("rst_gnts", {30'd0, bus.pc_gnt, bus.ins_gnt}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      rand_inputs();
    end
    rst = 1'b0;
    bus.pc_req = 1'b0;  bus.ins_req = 1'b0;
    bus.mem_ack = 1'b0; bus.err_clr = 1'b0;
    bus.pc_addr = '0;   bus.ins_addr = '0;
    goto(cyc + 2);

    // Round robin with ack toggled immediately: 7-cycle minimum per transaction
    c0 = cyc;
    bus.pc_addr = 4'h3;
    bus.ins_addr = 4'hC;
    bus.pc_req = 1'b1;
    bus.ins_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = c0 + 1 + 7 * k;
      if (k % 2 == 0) begin
        expect_ev(EV_DATA, 2'b10, 8'b10100101, d);
        expect_ev(EV_NULL, 2'b00, 8'h00, d + 3);
        expect_ev(EV_INSG, 2'b00, 8'h00, d + 6);
      end else begin
        expect_ev(EV_DATA, 2'b01, 8'b01011010, d);
        expect_ev(EV_NULL, 2'b00, 8'h00, d + 3);
        expect_ev(EV_PCG, 2'b00, 8'h00, d + 6);
      end
    end
    for (int k = 0; k < 4; k++) begin
      d = c0 + 1 + 7 * k;
      goto(d);
      bus.mem_ack = 1'b1;
      goto(d + 3);
      bus.mem_ack = 1'b0;
    end
    goto(c0 + 28);
    bus.pc_req = 1'b0;
    bus.ins_req = 1'b0;
    goto(c0 + 30);

    // Single PC fetch, ack rises 2 cycles after DATA and falls 2 after NULL
    c0 = cyc;
    bus.pc_addr = 4'hA;
    bus.pc_req = 1'b1;
    expect_ev(EV_DATA, 2'b01, 8'b10011001, c0 + 1);
    expect_ev(EV_NULL, 2'b00, 8'h00, c0 + 6);
    expect_ev(EV_PCG, 2'b00, 8'h00, c0 + 11);
    goto(c0 + 1);
    chk("busy_data", {31'd0, bus.busy}, 32'd1);
    goto(c0 + 3);
    bus.mem_ack = 1'b1;
    goto(c0 + 8);
    bus.mem_ack = 1'b0;
    goto(c0 + 10);
    chk("busy_nullw", {31'd0, bus.busy}, 32'd1);
    chk("pc_gnt_early", {31'd0, bus.pc_gnt}, 32'd0);
    goto(c0 + 11);
    bus.pc_req = 1'b0;
    chk("busy_after_gnt", {31'd0, bus.busy}, 32'd0);
    goto(c0 + 13);

    // Stale ack held high in IDLE blocks the start
    c0 = cyc;
    bus.mem_ack = 1'b1;
    goto(c0 + 3);
    bus.pc_addr = 4'h5;
    bus.pc_req = 1'b1;
    expect_ev(EV_DATA, 2'b01, 8'b01100110, c0 + 9);
    expect_ev(EV_NULL, 2'b00, 8'h00, c0 + 12);
    expect_ev(EV_PCG, 2'b00, 8'h00, c0 + 15);
    goto(c0 + 6);
    chk("stale_busy", {31'd0, bus.busy}, 32'd0);
    bus.mem_ack = 1'b0;
    goto(c0 + 8);
    chk("stale_busy2", {31'd0, bus.busy}, 32'd0);
    goto(c0 + 9);
    bus.mem_ack = 1'b1;
    goto(c0 + 12);
    bus.mem_ack = 1'b0;
    goto(c0 + 15);
    bus.pc_req = 1'b0;
    goto(c0 + 17);

    // Timeout with ack never rising
    c0 = cyc;
    bus.ins_addr = 4'h5;
    bus.ins_req = 1'b1;
    expect_ev(EV_DATA, 2'b10, 8'b01100110, c0 + 1);
    expect_ev(EV_NULL, 2'b00, 8'h00, c0 + 9);
    expect_ev(EV_ERR, 2'b00, 8'h00, c0 + 9);
    goto(c0 + 8);
    chk("err_before_to", {31'd0, bus.err}, 32'd0);
    chk("busy_before_to", {31'd0, bus.busy}, 32'd1);
    goto(c0 + 9);
    bus.ins_req = 1'b0;
    chk("err_after_to", {31'd0, bus.err}, 32'd1);
    chk("busy_after_to", {31'd0, bus.busy}, 32'd0);
    goto(c0 + 11);
    bus.err_clr = 1'b1;
    goto(c0 + 12);
    bus.err_clr = 1'b0;
    chk("err_cleared", {31'd0, bus.err}, 32'd0);
    goto(c0 + 14);

    // Timeout coinciding with err_clr: set wins
    c0 = cyc;
    bus.ins_req = 1'b1;
    expect_ev(EV_DATA, 2'b10, 8'b01100110, c0 + 1);
    expect_ev(EV_NULL, 2'b00, 8'h00, c0 + 9);
    expect_ev(EV_ERR, 2'b00, 8'h00, c0 + 9);
    goto(c0 + 8);
    bus.err_clr = 1'b1;
    goto(c0 + 9);
    bus.err_clr = 1'b0;
    bus.ins_req = 1'b0;
    chk("err_set_wins", {31'd0, bus.err}, 32'd1);
    goto(c0 + 10);
    bus.err_clr = 1'b1;
    goto(c0 + 11);
    bus.err_clr = 1'b0;
    chk("err_cleared2", {31'd0, bus.err}, 32'd0);
    goto(c0 + 13);

    // Reset while DATA word is on the bus, request held through it
    c0 = cyc;
    bus.pc_addr = 4'hA;
    bus.pc_req = 1'b1;
    expect_ev(EV_DATA, 2'b01, 8'b10011001, c0 + 1);
    expect_ev(EV_NULL, 2'b00, 8'h00, c0 + 3);
    expect_ev(EV_DATA, 2'b01, 8'b10011001, c0 + 4);
    expect_ev(EV_NULL, 2'b00, 8'h00, c0 + 7);
    expect_ev(EV_PCG, 2'b00, 8'h00, c0 + 10);
    goto(c0 + 2);
    rst = 1'b1;
    goto(c0 + 3);
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_gnt", {31'd0, bus.pc_gnt}, 32'd0);
    goto(c0 + 4);
    bus.mem_ack = 1'b1;
    goto(c0 + 7);
    bus.mem_ack = 1'b0;
    goto(c0 + 10);
    bus.pc_req = 1'b0;
    goto(c0 + 14);

    chk("events_outstanding", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
